cpu_bus_req_queue: RTL and testbench
====================================

CPU_BUS_REQ_QUEUE -- requirements
Module: cpu_bus_req_queue

Interface
REQ-001 The block SHALL have these parameters: ADDR_WIDTH, default 64, address width; DATA_WIDTH, default 64, data width.
REQ-002 The block SHALL have these parameters: DEPTH, default 4, request FIFO entries (power of 2, at least 2); TIMEOUT_CYCLES, default 256, bus wait limit (at least 2).
REQ-003 The block SHALL have port clk, input, 1 bit: clock, all state rising-edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have ports in_valid (input, 1) and in_ready (output, 1): upstream request handshake.
REQ-006 The block SHALL have ports in_addr (input, ADDR_WIDTH), in_wdata (input, DATA_WIDTH), in_we (input, 1), in_be (input, 8) and in_tag (input, 4): request payload.
REQ-007 The block SHALL have ports bus_req (output, 1), bus_addr (output, ADDR_WIDTH), bus_wdata (output, DATA_WIDTH), bus_we (output, 1) and bus_be (output, 8): interconnect master port request.
REQ-008 The block SHALL have ports bus_rdata (input, DATA_WIDTH) and bus_ready (input, 1): interconnect master port response.
REQ-009 The block SHALL have ports rsp_valid (output, 1), rsp_tag (output, 4), rsp_rdata (output, DATA_WIDTH), rsp_we (output, 1) and rsp_err (output, 1): completion, one-cycle pulse, no backpressure.
REQ-010 The block SHALL have ports occupancy (output, $clog2(DEPTH+1)) and err_count (output, 16): FIFO fill level and timeout counter.

Function
REQ-011 The block SHALL accept a request into the FIFO tail on every cycle where in_valid and in_ready are both 1.
REQ-012 in_ready SHALL equal (occupancy < DEPTH), combinational from registered count; in_valid while full is ignored and occupancy is unchanged.
REQ-013 The FIFO SHALL keep the tag, addr, wdata, we and be of each entry; read and write pointers SHALL wrap modulo DEPTH.
REQ-014 The FSM SHALL have exactly two states, IDLE and ISSUE, and SHALL reset to IDLE.
REQ-015 In IDLE with occupancy > 0: pop head into bus output registers, clear wait counter, next state ISSUE.
REQ-016 In IDLE with occupancy = 0: stay in IDLE.
REQ-017 bus_req SHALL be 1 exactly while in ISSUE.
REQ-018 bus_addr, bus_wdata, bus_we and bus_be SHALL hold stable throughout ISSUE.
REQ-019 In ISSUE with bus_ready = 1 at a clock edge: next cycle rsp_valid = 1, rsp_rdata = sampled bus_rdata, rsp_tag/rsp_we = issued values, rsp_err = 0; state goes to IDLE.
REQ-020 In ISSUE, wait counter SHALL increment each cycle without bus_ready.
REQ-021 If the counter reaches TIMEOUT_CYCLES-1 without bus_ready: next cycle rsp_valid = 1, rsp_err = 1, rsp_rdata = 0; state goes to IDLE; err_count increments, saturating at 16'hFFFF.
REQ-022 bus_ready high on the final timeout cycle SHALL count as success: no error, counter unchanged.
REQ-023 bus_ready or bus_rdata while in IDLE SHALL be ignored.
REQ-024 Minimum spacing SHALL be one IDLE cycle between consecutive bus_req pulses; issue-to-issue spacing is at least 3 cycles given 1-cycle ready.
REQ-025 Latency SHALL be: push at edge N, bus_req high from cycle N+2 if FSM idle and FIFO empty; rsp_valid one cycle after the bus_ready edge.
REQ-026 Push and pop in the same cycle SHALL leave occupancy unchanged; push into empty FIFO is not poppable until the next cycle.
REQ-027 Responses SHALL be returned strictly in acceptance order.

Reset
REQ-028 Asynchronous assertion of rst_n SHALL, mid-transfer included, clear the FIFO, pointers, occupancy, FSM (IDLE), wait counter and err_count.
REQ-029 During reset all outputs SHALL be 0, except in_ready = 1 once DEPTH > 0.
REQ-030 An in-flight request at reset SHALL be dropped with no rsp_valid pulse.

Verification
REQ-031 Bench scenario, single read: push addr 0x8000_0000, tag 3, bus_ready high 2 cycles after bus_req with rdata 0xDEAD_BEEF -> bus_addr 0x8000_0000, then rsp_valid with tag 3, rdata 0xDEAD_BEEF, err 0.
REQ-032 Bench scenario, fill: push 5 requests back-to-back with bus_ready held 0 -> in_ready drops after 4th accepted (occupancy 4 then 3 after first pop, 4 again); 5th accepted only when space.
REQ-033 Bench scenario, timeout: bus_ready never asserted -> rsp_valid with err 1, rdata 0, exactly TIMEOUT_CYCLES cycles after bus_req rises; err_count = 1.
REQ-034 Bench scenario, ordering: tags 1, 2, 3, 4 pushed, bus_ready latencies 3, 1, 5, 1 -> rsp_tag sequence 1, 2, 3, 4, one IDLE cycle between bus_req pulses.
REQ-035 Bench scenario, reset mid-ISSUE with 2 queued -> all outputs 0, occupancy 0, no rsp_valid; new push after release issues normally.
REQ-036 Bench scenario, late-ready boundary: bus_ready arrives on the final timeout cycle -> err 0, err_count unchanged.

Source files
------------

// File: rtl/cpu_bus_req_queue.sv
// Request queue between a CPU core and the interconnect: a small FIFO of
// requests feeding a two-state issue engine with a bounded wait for bus_ready.
module cpu_bus_req_queue #(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 64,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                         clk,
    input  logic                         rst_n,

    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ADDR_WIDTH-1:0]        in_addr,
    input  logic [DATA_WIDTH-1:0]        in_wdata,
    input  logic                         in_we,
    input  logic [7:0]                   in_be,
    input  logic [3:0]                   in_tag,

    output logic                         bus_req,
    output logic [ADDR_WIDTH-1:0]        bus_addr,
    output logic [DATA_WIDTH-1:0]        bus_wdata,
    output logic                         bus_we,
    output logic [7:0]                   bus_be,
    input  logic [DATA_WIDTH-1:0]        bus_rdata,
    input  logic                         bus_ready,

    output logic                         rsp_valid,
    output logic [3:0]                   rsp_tag,
    output logic [DATA_WIDTH-1:0]        rsp_rdata,
    output logic                         rsp_we,
    output logic                         rsp_err,

    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic [15:0]                  err_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES);
    localparam int EW = 4 + 1 + 8 + DATA_WIDTH + ADDR_WIDTH;

    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYCLES - 1);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_ISSUE = 1'b1;

    // FIFO bookkeeping
    logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            count_q, count_d;
    logic                     push;
    logic                     pop;
    logic [EW-1:0]            in_entry;
    logic [DEPTH-1:0][EW-1:0] mem_flat;
    logic [EW-1:0]            head;

    logic [3:0]               head_tag;
    logic                     head_we;
    logic [7:0]               head_be;
    logic [DATA_WIDTH-1:0]    head_wdata;
    logic [ADDR_WIDTH-1:0]    head_addr;

    // Issue engine
    logic                     state_q, state_d;
    logic [WW-1:0]            wait_q, wait_d;
    logic [ADDR_WIDTH-1:0]    bus_addr_q, bus_addr_d;
    logic [DATA_WIDTH-1:0]    bus_wdata_q, bus_wdata_d;
    logic                     bus_we_q, bus_we_d;
    logic [7:0]               bus_be_q, bus_be_d;
    logic [3:0]               bus_tag_q, bus_tag_d;

    // Completion
    logic                     rsp_valid_q, rsp_valid_d;
    logic [3:0]               rsp_tag_q, rsp_tag_d;
    logic [DATA_WIDTH-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic                     rsp_we_q, rsp_we_d;
    logic                     rsp_err_q, rsp_err_d;
    logic [15:0]              err_count_q, err_count_d;

    assign in_ready = (count_q < DEPTH_C);
    assign push     = in_valid & in_ready;
    assign in_entry = {in_tag, in_we, in_be, in_wdata, in_addr};

    // One storage slot per entry; a slot only loads when the write pointer selects it.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [EW-1:0] slot_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    slot_q <= '0;
                end else if (push && (wr_ptr_q == PW'(gi))) begin
                    slot_q <= in_entry;
                end
            end

            assign mem_flat[gi] = slot_q;
        end
    endgenerate

    assign head = mem_flat[rd_ptr_q];
    assign {head_tag, head_we, head_be, head_wdata, head_addr} = head;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // A pop only looks at the registered count, so an entry pushed into an
    // empty FIFO becomes visible to the engine one cycle later.
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        pop         = 1'b0;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_we_d    = bus_we_q;
        bus_be_d    = bus_be_q;
        bus_tag_d   = bus_tag_q;
        rsp_valid_d = 1'b0;
        rsp_tag_d   = rsp_tag_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_we_d    = rsp_we_q;
        rsp_err_d   = rsp_err_q;
        err_count_d = err_count_q;

        if (state_q == ST_IDLE) begin
            if (count_q != '0) begin
                pop         = 1'b1;
                bus_addr_d  = head_addr;
                bus_wdata_d = head_wdata;
                bus_we_d    = head_we;
                bus_be_d    = head_be;
                bus_tag_d   = head_tag;
                wait_d      = '0;
                state_d     = ST_ISSUE;
            end
        end else begin
            if (bus_ready) begin
                // Ready on the last allowed cycle still completes cleanly.
                rsp_valid_d = 1'b1;
                rsp_tag_d   = bus_tag_q;
                rsp_we_d    = bus_we_q;
                rsp_rdata_d = bus_rdata;
                rsp_err_d   = 1'b0;
                state_d     = ST_IDLE;
            end else if (wait_q == WAIT_LAST) begin
                rsp_valid_d = 1'b1;
                rsp_tag_d   = bus_tag_q;
                rsp_we_d    = bus_we_q;
                rsp_rdata_d = '0;
                rsp_err_d   = 1'b1;
                state_d     = ST_IDLE;
                if (err_count_q != 16'hFFFF) begin
                    err_count_d = err_count_q + 16'd1;
                end
            end else begin
                wait_d = wait_q + WW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= ST_IDLE;
            wait_q      <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_we_q    <= 1'b0;
            bus_be_q    <= '0;
            bus_tag_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_tag_q   <= '0;
            rsp_rdata_q <= '0;
            rsp_we_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            wait_q      <= wait_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_we_q    <= bus_we_d;
            bus_be_q    <= bus_be_d;
            bus_tag_q   <= bus_tag_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_we_q    <= rsp_we_d;
            rsp_err_q   <= rsp_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus_req   = (state_q == ST_ISSUE);
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_we    = bus_we_q;
    assign bus_be    = bus_be_q;

    assign rsp_valid = rsp_valid_q;
    assign rsp_tag   = rsp_tag_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_we    = rsp_we_q;
    assign rsp_err   = rsp_err_q;

    assign occupancy = count_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_cpu_bus_req_queue.sv
// Directed bench for cpu_bus_req_queue: a bus responder with per-request
// latency and a scoreboard of expected completions in acceptance order.
module tb_cpu_bus_req_queue;

    localparam int AW    = 64;
    localparam int DW    = 64;
    localparam int DEPTH = 4;
    localparam int T     = 24;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_wdata;
    logic          in_we;
    logic [7:0]    in_be;
    logic [3:0]    in_tag;
    logic          bus_req;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic          bus_we;
    logic [7:0]    bus_be;
    logic [DW-1:0] bus_rdata;
    logic          bus_ready;
    logic          rsp_valid;
    logic [3:0]    rsp_tag;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_we;
    logic          rsp_err;
    logic [2:0]    occupancy;
    logic [15:0]   err_count;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int issue_cyc   = 0;
    logic [15:0] exp_errs;

    typedef struct {
        logic [3:0]  tag;
        logic        we;
        logic [63:0] rdata;
        logic        err;
        int          delay;
    } exp_t;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] wdata;
        logic        we;
        logic [7:0]  be;
        int          lat;
        logic [63:0] rdata;
    } bus_t;

    exp_t sb_q[$];
    bus_t bus_q[$];

    cpu_bus_req_queue #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
        .in_wdata(in_wdata), .in_we(in_we), .in_be(in_be), .in_tag(in_tag),
        .bus_req(bus_req), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_we(bus_we), .bus_be(bus_be), .bus_rdata(bus_rdata), .bus_ready(bus_ready),
        .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_rdata(rsp_rdata),
        .rsp_we(rsp_we), .rsp_err(rsp_err),
        .occupancy(occupancy), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // lat < 0 or lat >= T means the responder never raises bus_ready.
    task automatic expect_req(input logic [3:0] tag, input logic [63:0] addr,
                              input logic [63:0] wdata, input logic we,
                              input logic [7:0] be, input int lat,
                              input logic [63:0] rdata);
        exp_t e;
        bus_t b;
        b.addr = addr; b.wdata = wdata; b.we = we; b.be = be; b.lat = lat; b.rdata = rdata;
        bus_q.push_back(b);
        e.tag   = tag;
        e.we    = we;
        e.err   = (lat < 0) || (lat >= T);
        e.rdata = e.err ? 64'h0 : rdata;
        e.delay = e.err ? T : lat + 1;
        sb_q.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input logic [3:0] tag, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic we,
                        input logic [7:0] be, input int lat, input logic [63:0] rdata);
        int guard;
        in_valid = 1'b1; in_tag = tag; in_addr = addr; in_wdata = wdata;
        in_we = we; in_be = be;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("push_in_ready", 64'(in_ready), 64'(1));
        expect_req(tag, addr, wdata, we, be, lat, rdata);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        in_valid = 1'b0;
        guard = 0;
        while ((sb_q.size() != 0 || bus_req) && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        check("drain_scoreboard_empty", 64'(sb_q.size()), 64'(0));
        repeat (2) @(negedge clk);
    endtask

    // Bus responder: checks the issued request and raises bus_ready after its latency.
    initial begin
        bus_t cur;
        int   cnt;
        bus_ready = 1'b0;
        bus_rdata = '0;
        cnt = 0;
        cur.lat = -1; cur.addr = '0; cur.wdata = '0; cur.we = 1'b0; cur.be = '0; cur.rdata = '0;
        forever begin
            @(negedge clk);
            if (!bus_req) begin
                cnt = 0;
                bus_ready = 1'($urandom_range(0, 1));
                bus_rdata = {$urandom, $urandom};
            end else begin
                cnt++;
                if (cnt == 1) begin
                    issue_cyc = cyc;
                    check("issue_has_request", 64'(bus_q.size() != 0), 64'(1));
                    if (bus_q.size() != 0) cur = bus_q.pop_front();
                    else cur.lat = -1;
                end
                check("bus_addr", bus_addr, cur.addr);
                check("bus_wdata", bus_wdata, cur.wdata);
                check("bus_we", 64'(bus_we), 64'(cur.we));
                check("bus_be", 64'(bus_be), 64'(cur.be));
                if (cur.lat >= 0 && cnt == cur.lat + 1) begin
                    bus_ready = 1'b1;
                    bus_rdata = cur.rdata;
                end else begin
                    bus_ready = 1'b0;
                    bus_rdata = {$urandom, $urandom};
                end
            end
        end
    end

    // Completion checker: pops the scoreboard on every rsp_valid pulse.
    initial begin
        exp_t e;
        logic gap_pending;
        gap_pending = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                gap_pending = 1'b0;
            end else begin
                if (gap_pending) begin
                    check("issue_after_one_idle", 64'(bus_req), 64'(1));
                    gap_pending = 1'b0;
                end
                if (rsp_valid) begin
                    check("bus_req_low_on_rsp", 64'(bus_req), 64'(0));
                    if (sb_q.size() == 0) begin
                        check("rsp_unexpected", 64'(rsp_valid), 64'(0));
                    end else begin
                        e = sb_q.pop_front();
                        check("rsp_tag", 64'(rsp_tag), 64'(e.tag));
                        check("rsp_rdata", rsp_rdata, e.rdata);
                        check("rsp_err", 64'(rsp_err), 64'(e.err));
                        check("rsp_we", 64'(rsp_we), 64'(e.we));
                        check("rsp_delay", 64'(cyc - issue_cyc), 64'(e.delay));
                    end
                    gap_pending = (occupancy != '0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b1;
        in_valid = 1'b0; in_addr = '0; in_wdata = '0; in_we = 1'b0; in_be = '0; in_tag = '0;
        exp_errs = 16'd0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_bus_req", 64'(bus_req), 64'(0));
        check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        check("reset_occupancy", 64'(occupancy), 64'(0));
        check("reset_err_count", 64'(err_count), 64'(0));
        check("reset_in_ready", 64'(in_ready), 64'(1));
        check("reset_bus_addr", bus_addr, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single read with latency check
        push(4'd3, 64'h8000_0000, 64'h0, 1'b0, 8'hFF, 2, 64'hDEAD_BEEF);
        check("latency_n1_bus_req", 64'(bus_req), 64'(0));
        check("latency_n1_occupancy", 64'(occupancy), 64'(1));
        @(negedge clk);
        check("latency_n2_bus_req", 64'(bus_req), 64'(1));
        check("single_bus_addr", bus_addr, 64'h8000_0000);
        check("single_occupancy_after_pop", 64'(occupancy), 64'(0));
        drain();

        // Timeout, late-ready boundary, and a ready that arrives one cycle too late
        push(4'd5, 64'h1000, 64'h55, 1'b1, 8'h0F, -1, 64'h0);
        drain();
        exp_errs = exp_errs + 16'd1;
        check("timeout_err_count", 64'(err_count), 64'(exp_errs));
        push(4'd6, 64'h2000, 64'h0, 1'b0, 8'hFF, T - 1, 64'h1234_5678_9ABC_DEF0);
        drain();
        check("late_ready_err_count", 64'(err_count), 64'(exp_errs));
        push(4'd7, 64'h3000, 64'h0, 1'b0, 8'hFF, T, 64'h77);
        drain();
        exp_errs = exp_errs + 16'd1;
        check("too_late_err_count", 64'(err_count), 64'(exp_errs));

        // Ordering with mixed latencies
        push(4'd1, 64'hA000_0001, 64'h11, 1'b0, 8'hFF, 3, 64'h1111);
        push(4'd2, 64'hA000_0002, 64'h22, 1'b1, 8'hF0, 1, 64'h2222);
        push(4'd3, 64'hA000_0003, 64'h33, 1'b0, 8'h0F, 5, 64'h3333);
        push(4'd4, 64'hA000_0004, 64'h44, 1'b1, 8'h3C, 1, 64'h4444);
        drain();

        // Fill: a blocker holds the engine while four entries fill the FIFO
        push(4'd8, 64'hB000_0000, 64'h88, 1'b1, 8'hFF, 12, 64'h8888);
        @(negedge clk);
        check("fill_blocker_issued", 64'(bus_req), 64'(1));
        for (int k = 1; k <= 4; k++) begin
            push(4'(8 + k), 64'hB000_0000 + 64'(k), 64'(k), 1'b0, 8'hFF, 0, 64'(k * 16));
            check("fill_occupancy", 64'(occupancy), 64'(k));
        end
        in_valid = 1'b1; in_tag = 4'd13; in_addr = 64'hB000_0005; in_wdata = 64'h5;
        in_we = 1'b0; in_be = 8'hFF;
        check("fill_full_in_ready", 64'(in_ready), 64'(0));
        check("fill_full_occupancy", 64'(occupancy), 64'(4));
        begin
            int guard;
            guard = 0;
            while (!in_ready && guard < 100) begin
                @(negedge clk);
                guard++;
            end
        end
        check("fill_space_in_ready", 64'(in_ready), 64'(1));
        check("fill_after_pop_occupancy", 64'(occupancy), 64'(3));
        expect_req(4'd13, 64'hB000_0005, 64'h5, 1'b0, 8'hFF, 0, 64'h50);
        @(negedge clk);
        in_valid = 1'b0;
        check("fill_refilled_occupancy", 64'(occupancy), 64'(4));
        drain();

        // Reset while a request is in flight and two more are queued
        push(4'd14, 64'hC000_0000, 64'hE, 1'b1, 8'hFF, -1, 64'h0);
        push(4'd15, 64'hC000_0001, 64'hF, 1'b0, 8'hFF, 0, 64'hF0);
        push(4'd0, 64'hC000_0002, 64'h10, 1'b0, 8'hFF, 0, 64'h100);
        check("pre_reset_bus_req", 64'(bus_req), 64'(1));
        check("pre_reset_occupancy", 64'(occupancy), 64'(2));
        #2 rst_n = 1'b0;
        #1;
        check("rst_bus_req", 64'(bus_req), 64'(0));
        check("rst_bus_addr", bus_addr, 64'h0);
        check("rst_bus_wdata", bus_wdata, 64'h0);
        check("rst_bus_we", 64'(bus_we), 64'(0));
        check("rst_bus_be", 64'(bus_be), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rsp_tag", 64'(rsp_tag), 64'(0));
        check("rst_rsp_rdata", rsp_rdata, 64'h0);
        check("rst_rsp_err", 64'(rsp_err), 64'(0));
        check("rst_rsp_we", 64'(rsp_we), 64'(0));
        check("rst_occupancy", 64'(occupancy), 64'(0));
        check("rst_err_count", 64'(err_count), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        sb_q.delete();
        bus_q.delete();
        exp_errs = 16'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_reset_idle_bus_req", 64'(bus_req), 64'(0));
        push(4'd2, 64'hD000_0000, 64'h99, 1'b0, 8'hFF, 1, 64'hCAFE_F00D);
        @(negedge clk);
        check("post_reset_issue", 64'(bus_req), 64'(1));
        drain();
        check("post_reset_err_count", 64'(err_count), 64'(exp_errs));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
